// File: rtl/ch0re_alu_arbiter_pkg.sv
// rtl/ch0re_alu_arbiter_pkg.sv - ALU op/width types and request/response records for the shared-ALU arbiter
package ch0re_alu_arbiter_pkg;

    localparam int XLEN      = 64;
    localparam int TAG_W_MAX = 8;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    // DATA_WORD operates on the low 32 bits and sign-extends the result
    typedef enum logic {
        DATA_DWORD = 1'b0,
        DATA_WORD  = 1'b1
    } data_type_e;

    typedef struct packed {
        alu_op_e                op;
        data_type_e             i64;
        logic [XLEN-1:0]        s1;
        logic [XLEN-1:0]        s2;
        logic [TAG_W_MAX-1:0]   tag;
    } alu_req_t;

    typedef struct packed {
        logic [XLEN-1:0]        res;
        logic                   zero;
        logic                   less;
        logic [TAG_W_MAX-1:0]   tag;
    } alu_rsp_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ch0re_alu_arbiter_if.sv
// rtl/ch0re_alu_arbiter_if.sv - requester bus of the arbiter and the operand/result bus of the shared ALU
interface ch0re_alu_arbiter_if
    import ch0re_alu_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int TAG_W = 4
);
    logic [NREQ-1:0]  i_req_valid;
    logic [NREQ-1:0]  o_req_ready;
    alu_op_e          i_req_op  [NREQ];
    data_type_e       i_req_i64 [NREQ];
    logic [63:0]      i_req_s1  [NREQ];
    logic [63:0]      i_req_s2  [NREQ];
    logic [TAG_W-1:0] i_req_tag [NREQ];
    logic [NREQ-1:0]  o_rsp_valid;
    logic [NREQ-1:0]  i_rsp_ready;
    logic [63:0]      o_rsp_res;
    logic             o_rsp_zero;
    logic             o_rsp_less;
    logic [TAG_W-1:0] o_rsp_tag;

    modport master (
        output i_req_valid, i_req_op, i_req_i64, i_req_s1, i_req_s2, i_req_tag, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_res, o_rsp_zero, o_rsp_less, o_rsp_tag
    );

    modport slave (
        input  i_req_valid, i_req_op, i_req_i64, i_req_s1, i_req_s2, i_req_tag, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_res, o_rsp_zero, o_rsp_less, o_rsp_tag
    );
endinterface

interface ch0re_alu_intf
    import ch0re_alu_arbiter_pkg::*;
;
    alu_op_e     i_op;
    data_type_e  i_i64;
    logic [63:0] i_s1;
    logic [63:0] i_s2;
    logic [63:0] o_res;
    logic        o_flag_zero;
    logic        o_flag_less;
    logic        o_br_taken;

    modport master (
        output i_op, i_i64, i_s1, i_s2,
        input  o_res, o_flag_zero, o_flag_less, o_br_taken
    );

    modport slave (
        input  i_op, i_i64, i_s1, i_s2,
        output o_res, o_flag_zero, o_flag_less, o_br_taken
    );
endinterface

// File: rtl/ch0re_alu_arbiter_alu.sv
// rtl/ch0re_alu_arbiter_alu.sv - combinational 64/32-bit integer ALU shared by all requesters
module ch0re_alu
    import ch0re_alu_arbiter_pkg::*;
(
    ch0re_alu_intf.slave alu
);
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic [5:0]  shamt;

    // word ops run on sign-extended operands so signed/unsigned compares and SRA stay correct
    always_comb begin
        word  = (alu.i_i64 == DATA_WORD);
        a     = word ? sext32(alu.i_s1[31:0]) : alu.i_s1;
        b     = word ? sext32(alu.i_s2[31:0]) : alu.i_s2;
        shamt = word ? {1'b0, b[4:0]} : b[5:0];
        r     = '0;
        case (alu.i_op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = a << shamt;
            ALU_SRL:  r = word ? ({32'b0, a[31:0]} >> shamt) : (a >> shamt);
            ALU_SRA:  r = $signed(a) >>> shamt;
            ALU_SLT:  r = {63'b0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {63'b0, a < b};
            default:  r = '0;
        endcase
        alu.o_res = word ? sext32(r[31:0]) : r;
    end

    assign alu.o_flag_zero = (alu.o_res == 64'd0);
    assign alu.o_flag_less = $signed(a) < $signed(b);
    assign alu.o_br_taken  = alu.o_flag_zero;
endmodule

// File: rtl/ch0re_alu_arbiter_rr.sv
// rtl/ch0re_alu_arbiter_rr.sv - combinational round-robin grant, scanning upward from ptr+1 with wrap
module ch0re_rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant
);
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ch0re_alu_arbiter.sv
// rtl/ch0re_alu_arbiter.sv - round-robin sharing of one ALU between NREQ requesters with a registered response slot
module ch0re_alu_arbiter
    import ch0re_alu_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int TAG_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    ch0re_alu_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   rsp_id;
    logic [PW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt;
    logic            rsp_busy;
    logic            slot_free;
    logic            accept;
    alu_req_t        sel_req;
    alu_rsp_t        rsp_q;

    ch0re_alu_intf alu_bus ();

    // the slot can take a new op in the same edge the pending response drains
    assign slot_free = !rsp_busy || bus.i_rsp_ready[rsp_id];

    ch0re_rr_arbiter #(.N(NREQ)) u_rr (
        .req   (bus.i_req_valid),
        .ptr   (ptr),
        .en    (slot_free),
        .grant (gnt)
    );

    assign accept          = |gnt;
    assign bus.o_req_ready = gnt;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) gnt_idx = PW'(i);
        end
    end

    always_comb begin
        sel_req.op  = bus.i_req_op[gnt_idx];
        sel_req.i64 = bus.i_req_i64[gnt_idx];
        sel_req.s1  = bus.i_req_s1[gnt_idx];
        sel_req.s2  = bus.i_req_s2[gnt_idx];
        sel_req.tag = TAG_W_MAX'(bus.i_req_tag[gnt_idx]);
    end

    assign alu_bus.i_op  = sel_req.op;
    assign alu_bus.i_i64 = sel_req.i64;
    assign alu_bus.i_s1  = sel_req.s1;
    assign alu_bus.i_s2  = sel_req.s2;

    ch0re_alu u_alu (
        .alu (alu_bus)
    );

    wire                 unused_br_taken = alu_bus.o_br_taken;
    wire [TAG_W_MAX-1:0] unused_tag_hi   = rsp_q.tag;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_busy <= 1'b0;
            rsp_id   <= '0;
            ptr      <= PW'(NREQ - 1);
            rsp_q    <= '0;
        end else if (accept) begin
            rsp_busy   <= 1'b1;
            rsp_id     <= gnt_idx;
            ptr        <= gnt_idx;
            rsp_q.res  <= alu_bus.o_res;
            rsp_q.zero <= alu_bus.o_flag_zero;
            rsp_q.less <= alu_bus.o_flag_less;
            rsp_q.tag  <= sel_req.tag;
        end else if (rsp_busy && bus.i_rsp_ready[rsp_id]) begin
            rsp_busy <= 1'b0;
        end
    end

    always_comb begin
        bus.o_rsp_valid = '0;
        if (rsp_busy) bus.o_rsp_valid[rsp_id] = 1'b1;
    end

    assign bus.o_rsp_res  = rsp_q.res;
    assign bus.o_rsp_zero = rsp_q.zero;
    assign bus.o_rsp_less = rsp_q.less;
    assign bus.o_rsp_tag  = rsp_q.tag[TAG_W-1:0];
endmodule

// File: tb/tb_ch0re_alu_arbiter.sv
// tb/tb_ch0re_alu_arbiter.sv - directed and randomized checks of the shared-ALU arbiter against a behavioural model
module tb_ch0re_alu_arbiter;
    import ch0re_alu_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ch0re_alu_arbiter_if #(.NREQ(N), .TAG_W(TW)) bus ();

    ch0re_alu_arbiter #(.NREQ(N), .TAG_W(TW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    bit          m_busy;
    int          m_id;
    int          m_ptr;
    logic [63:0] m_res;
    bit          m_zero;
    bit          m_less;
    logic [TW-1:0] m_tag;
    int          last_acc;
    logic [N-1:0] dut_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_alu(input alu_op_e op, input data_type_e dt,
                                    input logic [63:0] s1, input logic [63:0] s2,
                                    output logic [63:0] res, output bit less);
        if (dt == DATA_WORD) begin
            int a, b, r, sh;
            int unsigned ua, ub;
            a  = int'(s1[31:0]);
            b  = int'(s2[31:0]);
            ua = s1[31:0];
            ub = s2[31:0];
            sh = int'(s2[4:0]);
            case (op)
                ALU_ADD:  r = a + b;
                ALU_SUB:  r = a - b;
                ALU_AND:  r = a & b;
                ALU_OR:   r = a | b;
                ALU_XOR:  r = a ^ b;
                ALU_SLL:  r = a << sh;
                ALU_SRL:  r = int'(ua >> sh);
                ALU_SRA:  r = a >>> sh;
                ALU_SLT:  r = (a < b) ? 1 : 0;
                ALU_SLTU: r = (ua < ub) ? 1 : 0;
                default:  r = 0;
            endcase
            res  = 64'(longint'(r));
            less = (a < b);
        end else begin
            longint a, b, r;
            longint unsigned ua, ub;
            int sh;
            a  = longint'(s1);
            b  = longint'(s2);
            ua = s1;
            ub = s2;
            sh = int'(s2[5:0]);
            case (op)
                ALU_ADD:  r = a + b;
                ALU_SUB:  r = a - b;
                ALU_AND:  r = a & b;
                ALU_OR:   r = a | b;
                ALU_XOR:  r = a ^ b;
                ALU_SLL:  r = a << sh;
                ALU_SRL:  r = longint'(ua >> sh);
                ALU_SRA:  r = a >>> sh;
                ALU_SLT:  r = (a < b) ? 1 : 0;
                ALU_SLTU: r = (ua < ub) ? 1 : 0;
                default:  r = 0;
            endcase
            res  = 64'(r);
            less = (a < b);
        end
    endfunction

    function automatic int exp_grant();
        if (m_busy && !bus.i_rsp_ready[m_id]) return -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (bus.i_req_valid[c]) return c;
        end
        return -1;
    endfunction

    // compare one cycle against the model, then advance the model across the next edge
    task automatic cycle();
        int g;
        logic [N-1:0] er, ev;
        logic [63:0] r;
        bit l;
        #1;
        g  = exp_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        ev = '0;
        if (m_busy) ev[m_id] = 1'b1;
        dut_ready = bus.o_req_ready;
        check("req_ready", bus.o_req_ready, er);
        check("rsp_valid", bus.o_rsp_valid, ev);
        if (m_busy) begin
            check("rsp_res", bus.o_rsp_res, m_res);
            check("rsp_zero", bus.o_rsp_zero, m_zero);
            check("rsp_less", bus.o_rsp_less, m_less);
            check("rsp_tag", bus.o_rsp_tag, m_tag);
        end
        last_acc = g;
        if (g >= 0) begin
            ref_alu(bus.i_req_op[g], bus.i_req_i64[g], bus.i_req_s1[g], bus.i_req_s2[g], r, l);
            m_res  = r;
            m_less = l;
            m_zero = (r == 64'd0);
            m_tag  = bus.i_req_tag[g];
            m_busy = 1'b1;
            m_id   = g;
            m_ptr  = g;
        end else if (m_busy && bus.i_rsp_ready[m_id]) begin
            m_busy = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst             = 1'b1;
        bus.i_req_valid = '0;
        bus.i_rsp_ready = '0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        m_busy   = 1'b0;
        m_id     = 0;
        m_ptr    = N - 1;
        m_res    = '0;
        m_zero   = 1'b0;
        m_less   = 1'b0;
        m_tag    = '0;
        last_acc = -1;
        #1;
        check("rst_rsp_valid", bus.o_rsp_valid, 0);
        check("rst_rsp_res", bus.o_rsp_res, 0);
        check("rst_rsp_flags", {bus.o_rsp_zero, bus.o_rsp_less}, 0);
        check("rst_rsp_tag", bus.o_rsp_tag, 0);
    endtask

    task automatic set_req(input int i, input alu_op_e op, input data_type_e dt,
                           input logic [63:0] a, input logic [63:0] b, input logic [TW-1:0] t);
        bus.i_req_valid[i] = 1'b1;
        bus.i_req_op[i]    = op;
        bus.i_req_i64[i]   = dt;
        bus.i_req_s1[i]    = a;
        bus.i_req_s2[i]    = b;
        bus.i_req_tag[i]   = t;
    endtask

    task automatic rand_req(input int i);
        logic [63:0] a, b;
        case ($urandom_range(0, 3))
            0: begin a = 64'($urandom_range(0, 255)); b = 64'($urandom_range(0, 255)); end
            1: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
            2: begin a = {$urandom, $urandom}; b = a; end
            default: begin a = 64'h0000_0000_7FFF_FFFF; b = 64'($urandom_range(0, 70)); end
        endcase
        set_req(i, alu_op_e'(4'($urandom_range(0, 9))), data_type_e'(1'($urandom_range(0, 1))),
                a, b, TW'($urandom));
    endtask

    // present one request with all responses consumed; n is the number of cycles until ready
    task automatic issue(input int i, input alu_op_e op, input data_type_e dt,
                         input logic [63:0] a, input logic [63:0] b, input logic [TW-1:0] t,
                         output int n);
        set_req(i, op, dt, a, b, t);
        bus.i_rsp_ready = '1;
        for (n = 1; n <= 16; n++) begin
            cycle();
            if (dut_ready[i]) break;
        end
        bus.i_req_valid[i] = 1'b0;
        check("issue_accepted", dut_ready[i], 1);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst             = 1'b1;
        bus.i_req_valid = '0;
        bus.i_rsp_ready = '0;
        for (int i = 0; i < N; i++) begin
            bus.i_req_op[i]  = ALU_ADD;
            bus.i_req_i64[i] = DATA_DWORD;
            bus.i_req_s1[i]  = '0;
            bus.i_req_s2[i]  = '0;
            bus.i_req_tag[i] = '0;
        end
        do_reset(2);

        issue(0, ALU_ADD, DATA_DWORD, 64'd5, 64'd7, 4'd3, n);
        check("t1_latency", n, 1);
        check("t1_rsp_valid", bus.o_rsp_valid, 4'b0001);
        check("t1_res", bus.o_rsp_res, 64'd12);
        check("t1_tag", bus.o_rsp_tag, 3);
        check("t1_zero", bus.o_rsp_zero, 0);

        bus.i_rsp_ready = '1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 2; i++)
                if (!bus.i_req_valid[i] || last_acc == i) rand_req(i);
            cycle();
        end
        bus.i_req_valid = '0;
        cycle();

        set_req(0, ALU_ADD, DATA_DWORD, 64'd100, 64'd23, 4'd9);
        bus.i_rsp_ready = '0;
        cycle();
        bus.i_req_valid[0] = 1'b0;
        set_req(1, ALU_XOR, DATA_DWORD, 64'hF0, 64'h0F, 4'd5);
        repeat (3) begin
            #1;
            check("t3_stall_ready", bus.o_req_ready, 0);
            check("t3_hold_res", bus.o_rsp_res, 64'd123);
            cycle();
        end
        bus.i_rsp_ready[0] = 1'b1;
        #1;
        check("t3_release_ready", bus.o_req_ready, 4'b0010);
        cycle();
        bus.i_req_valid = '0;
        bus.i_rsp_ready = '1;
        #1;
        check("t3_new_res", bus.o_rsp_res, 64'hFF);
        cycle();

        issue(2, ALU_SUB, DATA_DWORD, 64'h10, 64'h10, 4'd1, n);
        check("t4_sub_res", bus.o_rsp_res, 0);
        check("t4_sub_zero", bus.o_rsp_zero, 1);
        issue(3, ALU_SLT, DATA_DWORD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd2, n);
        check("t4_slt_res", bus.o_rsp_res, 1);
        check("t4_slt_less", bus.o_rsp_less, 1);
        issue(1, ALU_ADD, DATA_WORD, 64'h7FFF_FFFF, 64'd1, 4'd4, n);
        check("t4_addw_res", bus.o_rsp_res, 64'hFFFF_FFFF_8000_0000);

        issue(0, ALU_OR, DATA_DWORD, 64'h1, 64'h2, 4'd7, n);
        do_reset(1);
        set_req(0, ALU_ADD, DATA_DWORD, 64'd1, 64'd1, 4'd1);
        set_req(1, ALU_ADD, DATA_DWORD, 64'd2, 64'd2, 4'd2);
        bus.i_rsp_ready = '1;
        #1;
        check("t5_prio_req0", bus.o_req_ready, 4'b0001);
        cycle();
        bus.i_req_valid[0] = 1'b0;
        cycle();
        bus.i_req_valid = '0;
        cycle();

        issue(1, ALU_AND, DATA_DWORD, 64'hFF, 64'h3C, 4'd6, n);
        set_req(1, ALU_SUB, DATA_DWORD, 64'd9, 64'd4, 4'd8);
        set_req(3, ALU_SLL, DATA_DWORD, 64'd1, 64'd4, 4'd10);
        #1;
        check("t6_first_grant3", bus.o_req_ready, 4'b1000);
        cycle();
        rand_req(3);
        #1;
        check("t6_then_grant1", bus.o_req_ready, 4'b0010);
        cycle();
        bus.i_req_valid = '0;
        cycle();

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) == 0) do_reset(1);
            for (int i = 0; i < N; i++) begin
                if (!bus.i_req_valid[i] || last_acc == i) begin
                    if ($urandom_range(0, 1) == 1) rand_req(i);
                    else bus.i_req_valid[i] = 1'b0;
                end
            end
            bus.i_rsp_ready = N'($urandom) | N'($urandom);
            cycle();
        end

        bus.i_req_valid = '0;
        bus.i_rsp_ready = '1;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
